// File: rtl/s32x_fb_arbiter_pkg.sv
// Shared types and defaults for the 32X framebuffer bank arbiter.
// Owners, FSM states and the latched request record live here.
package s32x_fb_arbiter_pkg;

  typedef enum logic [2:0] {
    OWN_NONE,
    OWN_DISP,
    OWN_FILL,
    OWN_WR,
    OWN_RD
  } fba_owner_t;

  typedef enum logic {
    ST_IDLE,
    ST_ACCESS
  } fba_state_t;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] d;
    logic [1:0]  be;
  } fba_req_t;

  localparam int ACC_CYC_DEF    = 4;
  localparam int STARVE_MAX_DEF = 4;

endpackage

// File: rtl/s32x_fb_arbiter_prio.sv
// Combinational grant pick: DISP > FILL > WR > RD, with a starved RD jumping
// ahead of WR. Refresh leaves only DISP eligible.
module s32x_fb_arbiter_prio (
  input  logic rfrh,
  input  logic disp_req,
  input  logic fill_req,
  input  logic wr_req,
  input  logic rd_req,
  input  logic starved,
  output logic pick_disp,
  output logic pick_fill,
  output logic pick_wr,
  output logic pick_rd
);

  always_comb begin
    pick_disp = 1'b0;
    pick_fill = 1'b0;
    pick_wr   = 1'b0;
    pick_rd   = 1'b0;
    if (disp_req) begin
      pick_disp = 1'b1;
    end else if (!rfrh) begin
      if (fill_req) begin
        pick_fill = 1'b1;
      end else if (rd_req && starved) begin
        pick_rd = 1'b1;
      end else if (wr_req) begin
        pick_wr = 1'b1;
      end else if (rd_req) begin
        pick_rd = 1'b1;
      end
    end
  end

endmodule

// File: rtl/s32x_fb_arbiter.sv
// Single-port framebuffer DRAM scheduler: one fixed-length access at a time,
// shared by display fetch, auto-fill, CPU write FIFO and CPU read.
module s32x_fb_arbiter
  import s32x_fb_arbiter_pkg::*;
#(
  parameter int ACC_CYC    = ACC_CYC_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rfrh,
  input  logic        disp_req,
  input  logic [15:0] disp_a,
  output logic [15:0] disp_q,
  output logic        disp_ack,
  input  logic        fill_req,
  input  logic [15:0] fill_a,
  input  logic [15:0] fill_d,
  output logic        fill_ack,
  input  logic        wr_req,
  input  logic [15:0] wr_a,
  input  logic [15:0] wr_d,
  input  logic [1:0]  wr_be,
  output logic        wr_ack,
  input  logic        rd_req,
  input  logic [15:0] rd_a,
  output logic [15:0] rd_q,
  output logic        rd_ack,
  output logic [15:0] mem_a,
  output logic [15:0] mem_do,
  output logic [1:0]  mem_we,
  output logic        mem_rd,
  input  logic [15:0] mem_di,
  output logic        busy
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  fba_state_t     state, state_next;
  fba_owner_t     owner, owner_next;
  fba_req_t       req_q, req_next;
  logic [3:0]     cnt, cnt_next;
  logic [SW-1:0]  starve_cnt, starve_next;
  logic           pick_disp, pick_fill, pick_wr, pick_rd;
  logic           starved, ack_any, grant_ok, done;

  assign starved  = (starve_cnt == SW'(STARVE_MAX));
  assign ack_any  = disp_ack | fill_ack | wr_ack | rd_ack;
  // The ACK clock is kept idle so a requester can drop or re-present its request.
  assign grant_ok = (state == ST_IDLE) && !ack_any;
  assign busy     = (state == ST_ACCESS);

  s32x_fb_arbiter_prio u_prio (
    .rfrh      (rfrh),
    .disp_req  (disp_req),
    .fill_req  (fill_req),
    .wr_req    (wr_req),
    .rd_req    (rd_req),
    .starved   (starved),
    .pick_disp (pick_disp),
    .pick_fill (pick_fill),
    .pick_wr   (pick_wr),
    .pick_rd   (pick_rd)
  );

  always_comb begin
    state_next = state;
    owner_next = owner;
    req_next   = req_q;
    cnt_next   = cnt;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (grant_ok && (pick_disp || pick_fill || pick_wr || pick_rd)) begin
          state_next = ST_ACCESS;
          cnt_next   = 4'(ACC_CYC - 1);
          if (pick_disp) begin
            owner_next = OWN_DISP;
            req_next   = '{a: disp_a, d: 16'h0000, be: 2'b00};
          end else if (pick_fill) begin
            owner_next = OWN_FILL;
            req_next   = '{a: fill_a, d: fill_d, be: 2'b11};
          end else if (pick_wr) begin
            owner_next = OWN_WR;
            req_next   = '{a: wr_a, d: wr_d, be: wr_be};
          end else begin
            owner_next = OWN_RD;
            req_next   = '{a: rd_a, d: 16'h0000, be: 2'b00};
          end
        end
      end
      ST_ACCESS: begin
        if (cnt == 4'd0) begin
          done       = 1'b1;
          state_next = ST_IDLE;
          owner_next = OWN_NONE;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Starvation only builds while a read is actually waiting behind writes.
  always_comb begin
    starve_next = starve_cnt;
    if (!rd_req || (grant_ok && pick_rd)) begin
      starve_next = '0;
    end else if (grant_ok && pick_wr && !starved) begin
      starve_next = starve_cnt + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      owner      <= OWN_NONE;
      req_q      <= '0;
      cnt        <= 4'd0;
      starve_cnt <= '0;
      disp_ack   <= 1'b0;
      fill_ack   <= 1'b0;
      wr_ack     <= 1'b0;
      rd_ack     <= 1'b0;
      disp_q     <= 16'h0000;
      rd_q       <= 16'h0000;
    end else begin
      state      <= state_next;
      owner      <= owner_next;
      req_q      <= req_next;
      cnt        <= cnt_next;
      starve_cnt <= starve_next;
      disp_ack   <= done && (owner == OWN_DISP);
      fill_ack   <= done && (owner == OWN_FILL);
      wr_ack     <= done && (owner == OWN_WR);
      rd_ack     <= done && (owner == OWN_RD);
      if (done && (owner == OWN_DISP)) disp_q <= mem_di;
      if (done && (owner == OWN_RD))   rd_q   <= mem_di;
    end
  end

  // Strobes hang off the state register so an async reset kills them at once.
  assign mem_a  = busy ? req_q.a  : 16'h0000;
  assign mem_do = busy ? req_q.d  : 16'h0000;
  assign mem_we = busy ? req_q.be : 2'b00;
  assign mem_rd = busy && ((owner == OWN_DISP) || (owner == OWN_RD));

endmodule

// File: tb/tb_s32x_fb_arbiter.sv
// Directed bench for s32x_fb_arbiter: read latency, priority, starvation,
// refresh blocking and async reset during an access.
module tb_s32x_fb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rfrh;
  logic        disp_req, fill_req, wr_req, rd_req;
  logic [15:0] disp_a, fill_a, fill_d, wr_a, wr_d, rd_a, mem_di;
  logic [1:0]  wr_be;
  logic [15:0] disp_q, rd_q, mem_a, mem_do;
  logic        disp_ack, fill_ack, wr_ack, rd_ack, mem_rd, busy;
  logic [1:0]  mem_we;

  int checks   = 0;
  int failures = 0;

  s32x_fb_arbiter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rfrh     (rfrh),
    .disp_req (disp_req),
    .disp_a   (disp_a),
    .disp_q   (disp_q),
    .disp_ack (disp_ack),
    .fill_req (fill_req),
    .fill_a   (fill_a),
    .fill_d   (fill_d),
    .fill_ack (fill_ack),
    .wr_req   (wr_req),
    .wr_a     (wr_a),
    .wr_d     (wr_d),
    .wr_be    (wr_be),
    .wr_ack   (wr_ack),
    .rd_req   (rd_req),
    .rd_a     (rd_a),
    .rd_q     (rd_q),
    .rd_ack   (rd_ack),
    .mem_a    (mem_a),
    .mem_do   (mem_do),
    .mem_we   (mem_we),
    .mem_rd   (mem_rd),
    .mem_di   (mem_di),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int rd_cycles, early_ack, rd_grants, wr_cnt, ack_seen;
  int wr_before [2];
  logic prev_busy;

  initial begin
    rst_n = 1'b0; rfrh = 1'b0;
    disp_req = 1'b0; fill_req = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
    disp_a = '0; fill_a = '0; fill_d = '0; wr_a = '0; wr_d = '0; wr_be = '0;
    rd_a = '0; mem_di = '0;
    step(2);
    check_output("rst_busy",   32'(busy),   32'h0);
    check_output("rst_mem_we", 32'(mem_we), 32'h0);
    check_output("rst_mem_rd", 32'(mem_rd), 32'h0);
    check_output("rst_mem_a",  32'(mem_a),  32'h0);
    check_output("rst_rd_q",   32'(rd_q),   32'h0);
    check_output("rst_acks",   32'({disp_ack, fill_ack, wr_ack, rd_ack}), 32'h0);
    rst_n = 1'b1;
    step(1);

    // single read: 4 read clocks, ack 5 clocks after the grant clock
    rd_req = 1'b1; rd_a = 16'h0123; mem_di = 16'hBEEF;
    step(1);
    check_output("rd_busy",   32'(busy),   32'h1);
    check_output("rd_mem_a",  32'(mem_a),  32'h0123);
    check_output("rd_mem_we", 32'(mem_we), 32'h0);
    rd_cycles = 0; early_ack = 0;
    for (int i = 0; i < 4; i++) begin
      if (mem_rd) rd_cycles++;
      if (rd_ack) early_ack++;
      step(1);
    end
    check_output("rd_strobe_cycles", 32'(rd_cycles), 32'd4);
    check_output("rd_early_ack",     32'(early_ack), 32'd0);
    check_output("rd_ack",           32'(rd_ack),    32'h1);
    check_output("rd_q",             32'(rd_q),      32'hBEEF);
    check_output("rd_strobe_off",    32'(mem_rd),    32'h0);
    rd_req = 1'b0; mem_di = 16'h0000;
    step(1);
    check_output("rd_ack_pulse", 32'(rd_ack), 32'h0);
    check_output("rd_q_hold",    32'(rd_q),   32'hBEEF);

    // DISP and WR together: DISP first, WR one clock after DISP_ACK
    disp_req = 1'b1; disp_a = 16'h1000;
    wr_req = 1'b1; wr_a = 16'h2000; wr_d = 16'h55AA; wr_be = 2'b10;
    mem_di = 16'h1234;
    step(1);
    check_output("disp_mem_a",  32'(mem_a),  32'h1000);
    check_output("disp_mem_rd", 32'(mem_rd), 32'h1);
    check_output("disp_mem_we", 32'(mem_we), 32'h0);
    step(4);
    check_output("disp_ack",    32'(disp_ack), 32'h1);
    check_output("disp_q",      32'(disp_q),   32'h1234);
    check_output("disp_no_wr_ack", 32'(wr_ack), 32'h0);
    disp_req = 1'b0;
    step(1);
    check_output("gap_idle", 32'(busy), 32'h0);
    step(1);
    check_output("wr_busy",   32'(busy),   32'h1);
    check_output("wr_mem_a",  32'(mem_a),  32'h2000);
    check_output("wr_mem_we", 32'(mem_we), 32'h2);
    check_output("wr_mem_do", 32'(mem_do), 32'h55AA);
    check_output("wr_mem_rd", 32'(mem_rd), 32'h0);
    step(4);
    check_output("wr_ack",       32'(wr_ack), 32'h1);
    check_output("wr_we_off",    32'(mem_we), 32'h0);

    // WR held + RD held: 4 WR grants, then RD, then 4 more WR before the next RD
    wr_a = 16'h3000; wr_be = 2'b11; rd_req = 1'b1; rd_a = 16'h4000; mem_di = 16'hCAFE;
    prev_busy = 1'b0; rd_grants = 0; wr_cnt = 0; wr_before[0] = -1; wr_before[1] = -1;
    for (int i = 0; i < 200 && rd_grants < 2; i++) begin
      step(1);
      if (busy && !prev_busy) begin
        if (mem_rd) begin
          wr_before[rd_grants] = wr_cnt;
          wr_cnt = 0;
          rd_grants++;
        end else if (mem_we != 2'b00) begin
          wr_cnt++;
        end
      end
      prev_busy = busy;
    end
    check_output("starve_rd_grants",  32'(rd_grants),    32'd2);
    check_output("starve_wr_first",   32'(wr_before[0]), 32'd4);
    check_output("starve_wr_cleared", 32'(wr_before[1]), 32'd4);
    check_output("starve_rd_addr",    32'(mem_a),        32'h4000);
    for (int i = 0; i < 10 && !rd_ack; i++) step(1);
    check_output("starve_rd_ack", 32'(rd_ack), 32'h1);
    check_output("starve_rd_q",   32'(rd_q),   32'hCAFE);
    wr_req = 1'b0; rd_req = 1'b0;
    step(1);

    // refresh: in-flight WR completes, FILL waits, DISP still served
    wr_req = 1'b1; wr_a = 16'h5000; wr_d = 16'h1111; wr_be = 2'b01;
    step(1);
    check_output("rf_wr_we", 32'(mem_we), 32'h1);
    rfrh = 1'b1; fill_req = 1'b1; fill_a = 16'h6000; fill_d = 16'h2222;
    step(3);
    check_output("rf_wr_still_busy", 32'(busy), 32'h1);
    step(1);
    check_output("rf_wr_ack", 32'(wr_ack), 32'h1);
    wr_req = 1'b0;
    step(3);
    check_output("rf_fill_blocked", 32'(busy), 32'h0);
    disp_req = 1'b1; disp_a = 16'h7000; mem_di = 16'h0BAD;
    step(1);
    check_output("rf_disp_mem_a",  32'(mem_a),  32'h7000);
    check_output("rf_disp_mem_rd", 32'(mem_rd), 32'h1);
    step(4);
    check_output("rf_disp_ack", 32'(disp_ack), 32'h1);
    disp_req = 1'b0;
    step(2);
    check_output("rf_fill_still_blocked", 32'(busy), 32'h0);
    rfrh = 1'b0;
    step(1);
    check_output("fill_mem_a",  32'(mem_a),  32'h6000);
    check_output("fill_mem_we", 32'(mem_we), 32'h3);
    check_output("fill_mem_do", 32'(mem_do), 32'h2222);

    // async reset in the 2nd FILL access clock
    step(1);
    check_output("fill_busy_2nd", 32'(busy), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check_output("arst_mem_we", 32'(mem_we), 32'h0);
    check_output("arst_busy",   32'(busy),   32'h0);
    check_output("arst_mem_a",  32'(mem_a),  32'h0);
    fill_req = 1'b0;
    step(2);
    rst_n = 1'b1;
    ack_seen = 0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (fill_ack) ack_seen++;
    end
    check_output("arst_no_fill_ack", 32'(ack_seen), 32'd0);
    check_output("arst_idle",        32'(busy),     32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
